// File: rtl/regfile_wb.sv
// regfile_wb: register file with a writeback port and registered status flags.
//
// Register 0 always reads as zero, and writes to it are dropped. The two read
// ports are combinational. When a read address matches the address being
// written in the same cycle, the read returns the incoming write data instead
// of the stored value. The zero and negative flags are registered from the
// writeback data whenever fe is set. This happens even when no register is
// written, so compare-only operations can still set the flags.
//
// Ports:
//   clk      - clock; all state changes on its rising edge
//   rst      - asynchronous active-high reset; clears all registers and flags
//   we       - register write enable
//   waddr    - write address (AW bits)
//   wdata    - writeback data (WIDTH bits)
//   fe       - flag-update enable
//   raddr_a  - read port A address
//   raddr_b  - read port B address
//   rdata_a  - read port A data (combinational, bypassed)
//   rdata_b  - read port B data (combinational, bypassed)
//   flag_z   - registered zero flag
//   flag_n   - registered negative flag (sign bit of wdata)
module regfile_wb #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             fe,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             flag_z,
  output logic             flag_n
);

  // Only registers 1..NREGS-1 have storage; register 0 is a constant zero.
  logic [WIDTH-1:0] stored_r [1:NREGS-1];
  logic [WIDTH-1:0] regs_s   [NREGS];
  logic             wr_valid_s;
  logic             flag_z_r;
  logic             flag_n_r;

  // A write to address 0 is a no-op, so it also never bypasses.
  assign wr_valid_s = we && (waddr != {AW{1'b0}});

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_reg
      // Storage for register gi; the async reset also drops a write on the reset edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stored_r[gi] <= {WIDTH{1'b0}};
        end else if (we && (waddr == AW'(gi))) begin
          stored_r[gi] <= wdata;
        end else begin
          stored_r[gi] <= stored_r[gi];
        end
      end
    end
  endgenerate

  // Full read view of the array, with register 0 tied to zero.
  always_comb begin
    regs_s[0] = {WIDTH{1'b0}};
    for (int i = 1; i < NREGS; i++) begin
      regs_s[i] = stored_r[i];
    end
  end

  // Read port A: the same-cycle write takes priority over the stored value.
  always_comb begin
    rdata_a = {WIDTH{1'b0}};
    if (wr_valid_s && (raddr_a == waddr)) begin
      rdata_a = wdata;
    end else begin
      rdata_a = regs_s[raddr_a];
    end
  end

  // Read port B: same structure as port A, so equal addresses give equal data.
  always_comb begin
    rdata_b = {WIDTH{1'b0}};
    if (wr_valid_s && (raddr_b == waddr)) begin
      rdata_b = wdata;
    end else begin
      rdata_b = regs_s[raddr_b];
    end
  end

  // Status flags: captured from wdata whenever fe is set, independent of we and waddr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z_r <= 1'b0;
      flag_n_r <= 1'b0;
    end else if (fe) begin
      flag_z_r <= (wdata == {WIDTH{1'b0}});
      flag_n_r <= wdata[WIDTH-1];
    end else begin
      flag_z_r <= flag_z_r;
      flag_n_r <= flag_n_r;
    end
  end

  assign flag_z = flag_z_r;
  assign flag_n = flag_n_r;

endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed test of regfile_wb (WIDTH=8, NREGS=8).
// Inputs change on the falling edge and outputs are sampled 1 ns later,
// well away from the rising edge.
module tb_regfile_wb;

  logic       clk;
  logic       rst;
  logic       we;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic       fe;
  logic [2:0] raddr_a;
  logic [2:0] raddr_b;
  logic [7:0] rdata_a;
  logic [7:0] rdata_b;
  logic       flag_z;
  logic       flag_n;

  int vec_cnt;
  int err_cnt;

  regfile_wb #(.WIDTH(8), .NREGS(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .fe      (fe),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .flag_z  (flag_z),
    .flag_n  (flag_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst     = 1'b1;
    we      = 1'b0;
    waddr   = 3'd0;
    wdata   = 8'h00;
    fe      = 1'b0;
    raddr_a = 3'd0;
    raddr_b = 3'd1;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_rdata_a", 32'(rdata_a), 32'h00);
    check_val("rst_rdata_b", 32'(rdata_b), 32'h00);
    check_val("rst_flag_z", 32'(flag_z), 32'h0);
    check_val("rst_flag_n", 32'(flag_n), 32'h0);
    rst = 1'b0;

    // Write 0xA5 to r3, then read it on both ports.
    we = 1'b1; waddr = 3'd3; wdata = 8'hA5;
    @(negedge clk);
    we = 1'b0; raddr_a = 3'd3; raddr_b = 3'd3;
    #1;
    check_val("r3_port_a", 32'(rdata_a), 32'hA5);
    check_val("r3_port_b", 32'(rdata_b), 32'hA5);

    // Writing 0xFF to r0 with fe set: r0 stays zero, but the flags update.
    we = 1'b1; waddr = 3'd0; wdata = 8'hFF; fe = 1'b1; raddr_a = 3'd0;
    #1;
    check_val("r0_no_bypass", 32'(rdata_a), 32'h00);
    @(negedge clk);
    we = 1'b0; fe = 1'b0;
    #1;
    check_val("r0_after_write", 32'(rdata_a), 32'h00);
    check_val("r0_flag_z", 32'(flag_z), 32'h0);
    check_val("r0_flag_n", 32'(flag_n), 32'h1);

    // r5 = 0x11, then overwrite it with 0x22 and read it back in the same cycle.
    we = 1'b1; waddr = 3'd5; wdata = 8'h11;
    @(negedge clk);
    wdata = 8'h22; raddr_a = 3'd5; raddr_b = 3'd3;
    #1;
    check_val("bypass_a", 32'(rdata_a), 32'h22);
    check_val("nobypass_b", 32'(rdata_b), 32'hA5);
    raddr_b = 3'd5;
    #1;
    check_val("bypass_b", 32'(rdata_b), 32'h22);
    @(negedge clk);
    we = 1'b0;
    #1;
    check_val("r5_stored_a", 32'(rdata_a), 32'h22);
    check_val("r5_stored_b", 32'(rdata_b), 32'h22);

    // Flags: wdata=0 with fe=1 sets Z; they are not bypassed, so n stays 1 until the edge.
    fe = 1'b1; wdata = 8'h00;
    #1;
    check_val("flag_n_pre_edge", 32'(flag_n), 32'h1);
    @(negedge clk);
    fe = 1'b0; wdata = 8'h80;
    #1;
    check_val("flag_z_set", 32'(flag_z), 32'h1);
    check_val("flag_n_clr", 32'(flag_n), 32'h0);
    @(negedge clk);
    #1;
    check_val("flag_z_hold", 32'(flag_z), 32'h1);
    check_val("flag_n_hold", 32'(flag_n), 32'h0);

    // Back-to-back writes to r6.
    we = 1'b1; waddr = 3'd6; wdata = 8'h01; raddr_a = 3'd6;
    #1;
    check_val("b2b_first", 32'(rdata_a), 32'h01);
    @(negedge clk);
    wdata = 8'h02;
    #1;
    check_val("b2b_second", 32'(rdata_a), 32'h02);
    @(negedge clk);
    we = 1'b0;
    #1;
    check_val("b2b_stored", 32'(rdata_a), 32'h02);

    // r2 = 0x33, then reset in the middle of a write of 0x44.
    we = 1'b1; waddr = 3'd2; wdata = 8'h33;
    @(negedge clk);
    we = 1'b0; raddr_a = 3'd2;
    #1;
    check_val("r2_written", 32'(rdata_a), 32'h33);
    we = 1'b1; waddr = 3'd2; wdata = 8'h44; fe = 1'b1; raddr_b = 3'd3;
    #1;
    rst = 1'b1;
    #1;
    check_val("rst_bypass_a", 32'(rdata_a), 32'h44);
    check_val("rst_async_b", 32'(rdata_b), 32'h00);
    check_val("rst_async_z", 32'(flag_z), 32'h0);
    check_val("rst_async_n", 32'(flag_n), 32'h0);
    @(negedge clk);
    rst = 1'b0; we = 1'b0; fe = 1'b0;
    #1;
    check_val("rst_drop_r2", 32'(rdata_a), 32'h00);
    check_val("rst_drop_z", 32'(flag_z), 32'h0);

    // The first edge after reset performs a normal write.
    we = 1'b1; waddr = 3'd7; wdata = 8'h5A;
    @(negedge clk);
    we = 1'b0; raddr_a = 3'd7;
    #1;
    check_val("post_rst_write", 32'(rdata_a), 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
